// File: rtl/conv_scatter_ctrl_pkg.sv
// Shared types and default sizing for the scatter-convolution sequencer.
// Holds the FSM state encoding plus the default K/N/ILEN/OLEN geometry.
// Derived sizes (output side, accumulator width) follow from those defaults.
package conv_pkg;

  localparam int K        = 3;
  localparam int N        = 2;
  localparam int ILEN     = 8;
  localparam int OLEN     = 2 * ILEN;
  localparam int OUT_SIDE = N + K - 1;
  localparam int ACC_LEN  = OLEN + $clog2(K * K) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    ACCUM  = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4
  } conv_state_t;

endpackage

// File: rtl/conv_scatter_ctrl_if.sv
// Kernel, pixel and result streams of the scatter-convolution sequencer.
// Pure wiring: no storage, so no latency of its own.
// Each stream is valid/ready; master is the environment, slave is the sequencer.
interface conv_scatter_ctrl_if #(
  parameter int ILEN = conv_pkg::ILEN,
  parameter int ALEN = conv_pkg::ACC_LEN
);

  logic            kern_valid;
  logic            kern_ready;
  logic [ILEN-1:0] kern_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [ILEN-1:0] pix_data;
  logic            out_valid;
  logic            out_ready;
  logic [ALEN-1:0] out_data;
  logic            out_last;

  modport master (
    output kern_valid, kern_data, pix_valid, pix_data, out_ready,
    input  kern_ready, pix_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  kern_valid, kern_data, pix_valid, pix_data, out_ready,
    output kern_ready, pix_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/conv_scatter_ctrl_mul.sv
// multiply_unit: one pixel times every kernel weight, K*K unsigned products.
// Latency: combinational, results valid in the same cycle as the inputs.
// Backpressure: none; the caller registers inputs and consumes products.
module multiply_unit #(
  parameter int K    = 3,
  parameter int ILEN = 8,
  parameter int OLEN = 16
) (
  input  logic [ILEN-1:0] i_pix,
  input  logic [ILEN-1:0] i_kern [K*K],
  output logic [OLEN-1:0] o_prod [K*K]
);

  for (genvar i = 0; i < K * K; i++) begin : g_mul
    assign o_prod[i] = OLEN'(i_pix) * OLEN'(i_kern[i]);
  end

endmodule

// File: rtl/conv_scatter_ctrl.sv
// Sequencer: load KxK kernel, scatter-accumulate NxN pixels, drain (N+K-1)^2 sums.
// Latency: a pixel accepted at edge t lands in the accumulator at edge t+1.
// Backpressure: only the result stream stalls (data/last held); CONV_SAT_EN clamps out_data.
module conv_scatter_ctrl #(
  parameter int K    = conv_pkg::K,
  parameter int N    = conv_pkg::N,
  parameter int ILEN = conv_pkg::ILEN,
  parameter int OLEN = conv_pkg::OLEN,
  parameter int ALEN = OLEN + $clog2(K * K) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  conv_scatter_ctrl_if.slave  io,
  output logic                busy,
  output logic                done
);

  import conv_pkg::*;

  localparam int KK  = K * K;
  localparam int OS  = N + K - 1;
  localparam int OS2 = OS * OS;
  localparam int KIW = $clog2(KK);
  localparam int AIW = $clog2(OS2);
  localparam int RW  = $clog2(N) + 1;

  conv_state_t     r_state;
  logic [KIW-1:0]  r_kidx;
  logic [RW-1:0]   r_prow;
  logic [RW-1:0]   r_pcol;
  logic [AIW-1:0]  r_didx;
  logic [ILEN-1:0] r_kern [KK];

  logic            r_s1_vld;
  logic [ILEN-1:0] r_s1_pix;
  logic [RW-1:0]   r_s1_row;
  logic [RW-1:0]   r_s1_col;

  logic [ALEN-1:0] r_acc [OS2];

  logic            r_kern_rdy;
  logic            r_pix_rdy;
  logic            r_out_vld;
  logic            r_out_last;
  logic            r_busy;
  logic            r_done;

  logic [OLEN-1:0] w_prod [KK];
  logic [ALEN-1:0] w_acc_sel;
  logic [ALEN-1:0] w_out_dat;
  logic            w_kern_hs;
  logic            w_pix_hs;
  logic            w_out_hs;

  assign w_kern_hs = io.kern_valid & r_kern_rdy;
  assign w_pix_hs  = io.pix_valid & r_pix_rdy;
  assign w_out_hs  = r_out_vld & io.out_ready;

  // Stage 1 products: registered pixel against the whole kernel register file.
  multiply_unit #(
    .K    (K),
    .ILEN (ILEN),
    .OLEN (OLEN)
  ) u_mul (
    .i_pix  (r_s1_pix),
    .i_kern (r_kern),
    .o_prod (w_prod)
  );

  // Control FSM: phase sequencing, counters, kernel capture and registered handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_kidx     <= '0;
      r_prow     <= '0;
      r_pcol     <= '0;
      r_didx     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_row   <= '0;
      r_s1_col   <= '0;
      r_kern_rdy <= 1'b0;
      r_pix_rdy  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < KK; i++) begin
        r_kern[i] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_s1_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kidx     <= '0;
            r_prow     <= '0;
            r_pcol     <= '0;
            r_didx     <= '0;
            r_kern_rdy <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= LOAD_K;
          end
        end
        LOAD_K: begin
          if (w_kern_hs) begin
            r_kern[r_kidx] <= io.kern_data;
            r_kidx         <= r_kidx + 1'b1;
            if (r_kidx == KIW'(KK - 1)) begin
              r_kern_rdy <= 1'b0;
              r_pix_rdy  <= 1'b1;
              r_state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_pix_hs) begin
            r_s1_vld <= 1'b1;
            r_s1_pix <= io.pix_data;
            r_s1_row <= r_prow;
            r_s1_col <= r_pcol;
            if (r_pcol == RW'(N - 1)) begin
              r_pcol <= '0;
              r_prow <= r_prow + 1'b1;
            end else begin
              r_pcol <= r_pcol + 1'b1;
            end
            if ((r_prow == RW'(N - 1)) && (r_pcol == RW'(N - 1))) begin
              r_pix_rdy <= 1'b0;
              r_state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Last pixel's accumulate commits on this edge; drain starts after it.
          r_out_vld  <= 1'b1;
          r_out_last <= (OS2 == 1);
          r_state    <= DRAIN;
        end
        DRAIN: begin
          if (w_out_hs) begin
            if (r_out_last) begin
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_didx     <= r_didx + 1'b1;
              r_out_last <= (r_didx == AIW'(OS2 - 2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage 2 scatter: each product lands on its own output cell, so every write index is distinct.
  always_ff @(posedge clk) begin
    if (!rst_n || ((r_state == IDLE) && start)) begin
      for (int o = 0; o < OS2; o++) begin
        r_acc[o] <= '0;
      end
    end else if (r_s1_vld) begin
      for (int kr = 0; kr < K; kr++) begin
        for (int kc = 0; kc < K; kc++) begin
          r_acc[AIW'((int'(r_s1_row) + kr) * OS + int'(r_s1_col) + kc)] <=
            r_acc[AIW'((int'(r_s1_row) + kr) * OS + int'(r_s1_col) + kc)] +
            ALEN'(w_prod[KIW'(kr * K + kc)]);
        end
      end
    end
  end

  assign w_acc_sel = r_acc[r_didx];

`ifdef CONV_SAT_EN
  localparam logic [ALEN-1:0] SAT_MAX = ALEN'({OLEN{1'b1}});
  assign w_out_dat = (w_acc_sel > SAT_MAX) ? SAT_MAX : w_acc_sel;
`else
  assign w_out_dat = w_acc_sel;
`endif

  // Accumulator and drain index are stable during a stall, so data holds without extra staging.
  assign io.out_data   = r_out_vld ? w_out_dat : '0;
  assign io.out_valid  = r_out_vld;
  assign io.out_last   = r_out_last;
  assign io.kern_ready = r_kern_rdy;
  assign io.pix_ready  = r_pix_rdy;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_conv_scatter_ctrl.sv
// Bench for conv_scatter_ctrl: directed and randomised jobs against a gather-form model.
// Latency: checks the full-rate job length from start to done.
// Backpressure: drives stalled, toggled and random out_ready and checks output stability.
module tb_conv_scatter_ctrl;

  import conv_pkg::*;

  localparam int KK   = K * K;
  localparam int NN   = N * N;
  localparam int OS   = OUT_SIDE;
  localparam int OS2  = OS * OS;
  localparam int ALEN = ACC_LEN;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  conv_scatter_ctrl_if #(.ILEN(ILEN), .ALEN(ALEN)) bus ();

  conv_scatter_ctrl #(
    .K    (K),
    .N    (N),
    .ILEN (ILEN),
    .OLEN (OLEN),
    .ALEN (ALEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .io    (bus),
    .busy  (busy),
    .done  (done)
  );

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     kern_a [KK];
  int     pix_a  [NN];
  longint exp_a  [OS2];
  longint got_a  [OS2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Gather form: each output cell sums every pixel/weight pair whose offsets meet there.
  task automatic build_model();
    for (int y = 0; y < OS; y++) begin
      for (int x = 0; x < OS; x++) begin
        longint s;
        s = 0;
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            int kr;
            int kc;
            kr = y - r;
            kc = x - c;
            if (kr >= 0 && kr < K && kc >= 0 && kc < K)
              s += longint'(pix_a[r*N+c]) * longint'(kern_a[kr*K+kc]);
          end
        end
`ifdef CONV_SAT_EN
        if (s > (longint'(1) << OLEN) - 1) s = (longint'(1) << OLEN) - 1;
`endif
        exp_a[y*OS+x] = s;
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_kern_ready"}, bus.kern_ready, 0);
    check({nm, "_pix_ready"},  bus.pix_ready,  0);
    check({nm, "_out_valid"},  bus.out_valid,  0);
    check({nm, "_out_last"},   bus.out_last,   0);
    check({nm, "_out_data"},   bus.out_data,   0);
    check({nm, "_busy"},       busy,           0);
    check({nm, "_done"},       done,           0);
  endtask

  // rmode: 0 always ready, 1 ready on every third cycle, 2 random ready.
  task automatic run_job(input int rmode, input bit gaps, input bit pix_in_load,
                         input bit start_in_accum, input bit chk_len, input string nm);
    int i;
    int guard;
    int got;
    int t0;
    bit hs;
    bit rdy;
    bit prev_stall;
    logic [ALEN-1:0] prev_dat;
    logic prev_last;
    build_model();
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    check({nm, "_busy_after_start"}, busy, 1);

    i = 0;
    guard = 0;
    bus.pix_valid = pix_in_load;
    bus.pix_data  = 8'hAA;
    while (i < KK && guard < 400) begin
      bus.kern_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.kern_data  = ILEN'(kern_a[i]);
      if (pix_in_load) check({nm, "_pix_ready_in_load"}, bus.pix_ready, 0);
      hs = bus.kern_valid && bus.kern_ready;
      step();
      guard++;
      if (hs) i++;
    end
    bus.kern_valid = 1'b0;
    bus.pix_valid  = 1'b0;
    check({nm, "_kern_accepted"}, i, KK);

    i = 0;
    guard = 0;
    while (i < NN && guard < 400) begin
      bus.pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pix_data  = ILEN'(pix_a[i]);
      start = start_in_accum;
      hs = bus.pix_valid && bus.pix_ready;
      step();
      guard++;
      if (hs) i++;
    end
    bus.pix_valid = 1'b0;
    start = 1'b0;
    check({nm, "_pix_accepted"}, i, NN);

    got = 0;
    guard = 0;
    prev_stall = 1'b0;
    prev_dat = '0;
    prev_last = 1'b0;
    while (got < OS2 && guard < 600) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      bus.out_ready = rdy;
      if (prev_stall) begin
        check({nm, "_stall_valid"}, bus.out_valid, 1);
        check({nm, "_stall_data"},  bus.out_data,  prev_dat);
        check({nm, "_stall_last"},  bus.out_last,  prev_last);
      end
      hs = bus.out_valid && rdy;
      if (hs) begin
        got_a[got] = longint'(bus.out_data);
        check($sformatf("%s_out%0d", nm, got), bus.out_data, exp_a[got]);
        check($sformatf("%s_last%0d", nm, got), bus.out_last, (got == OS2 - 1));
      end
      prev_stall = bus.out_valid && !rdy;
      prev_dat   = bus.out_data;
      prev_last  = bus.out_last;
      step();
      guard++;
      if (hs) got++;
    end
    bus.out_ready = 1'b0;
    check({nm, "_out_count"}, got, OS2);
    check({nm, "_done_pulse"}, done, 1);
    check({nm, "_busy_at_done"}, busy, 0);
    check({nm, "_valid_at_done"}, bus.out_valid, 0);
    if (chk_len) check({nm, "_job_cycles"}, cyc - t0, 1 + KK + NN + 1 + OS2);
  endtask

  task automatic set_test1();
    for (int i = 0; i < KK; i++) kern_a[i] = 1;
    for (int i = 0; i < NN; i++) pix_a[i] = i + 1;
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.kern_valid = 1'b0;
    bus.kern_data  = '0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.out_ready  = 1'b0;
    step();
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("post_reset");

    // All-ones kernel, pixels 1..4, full rate.
    set_test1();
    run_job(0, 1'b0, 1'b0, 1'b0, 1'b1, "t1");
    check("t1_spot_acc6", got_a[6], 10);
    check("t1_spot_acc15", got_a[15], 4);
    step();
    check("t1_done_clears", done, 0);

    // Centre-only kernel.
    for (int i = 0; i < KK; i++) kern_a[i] = (i == KK / 2) ? 1 : 0;
    pix_a[0] = 10; pix_a[1] = 20; pix_a[2] = 30; pix_a[3] = 40;
    run_job(0, 1'b0, 1'b0, 1'b0, 1'b0, "center");
    check("center_acc9", got_a[9], 30);

    // Test 1 again under a 1,0,0 ready pattern; start in the done cycle is accepted.
    set_test1();
    run_job(1, 1'b0, 1'b0, 1'b0, 1'b0, "toggle");

    // Saturating inputs.
    for (int i = 0; i < KK; i++) kern_a[i] = 255;
    for (int i = 0; i < NN; i++) pix_a[i] = 255;
    run_job(0, 1'b0, 1'b0, 1'b0, 1'b0, "max");
`ifdef CONV_SAT_EN
    check("max_acc5", got_a[5], 65535);
`else
    check("max_acc5", got_a[5], 260100);
`endif

    // Start accepted in the same cycle done pulses.
    set_test1();
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_kern_ready", bus.kern_ready, 1);

    // Reset mid-job after two pixels.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < KK; i++) begin
      bus.kern_valid = 1'b1;
      bus.kern_data  = 8'd1;
      step();
    end
    bus.kern_valid = 1'b0;
    check("mid_pix_ready", bus.pix_ready, 1);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'd7;
    step();
    step();
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("mid_reset_idle");

    set_test1();
    run_job(0, 1'b0, 1'b0, 1'b0, 1'b1, "t1_again");

    // Ignored start in ACCUM and pix_valid held during LOAD_K.
    set_test1();
    run_job(0, 1'b0, 1'b1, 1'b1, 1'b1, "ignore");

    // Randomised jobs with valid gaps and random stalls.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < KK; i++) kern_a[i] = $urandom_range(0, 255);
      for (int i = 0; i < NN; i++) pix_a[i] = $urandom_range(0, 255);
      run_job(2, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", j));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
